// File: rtl/except_ctrl_pkg.sv
// Shared CPU definitions: exception codes, CP0 status/cause bit positions
// and the exception-controller state encoding.
package except_ctrl_pkg;

  localparam logic [31:0] EXC_CODE_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_CODE_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_CODE_RI      = 32'h0000_000a;
  localparam logic [31:0] EXC_CODE_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_CODE_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_CODE_ERET    = 32'h0000_000e;

  localparam int STATUS_IE_BIT  = 0;
  localparam int STATUS_EXL_BIT = 1;
  localparam int STATUS_IM_LSB  = 8;
  localparam int STATUS_IM_MSB  = 15;
  localparam int CAUSE_IP_LSB   = 8;
  localparam int CAUSE_IP_MSB   = 15;

  // Bit positions inside exc_flags_i = {eret, ovf, trap, inst_invalid, syscall}
  localparam int FLAG_SYSCALL = 0;
  localparam int FLAG_RI      = 1;
  localparam int FLAG_TRAP    = 2;
  localparam int FLAG_OV      = 3;
  localparam int FLAG_ERET    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_DRAIN  = 2'd2
  } exc_state_e;

endpackage

// File: rtl/except_ctrl.sv
// MEM-stage exception controller: picks the highest-priority exception,
// reports it to CP0 for one cycle with a flush/redirect, then drains.
module except_ctrl
  import except_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic        stall_i,
  input  logic [4:0]  exc_flags_i,
  input  logic [31:0] inst_addr_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] cp0_inst_addr_o,
  output logic        cp0_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
);

  exc_state_e  state_q, state_d;
  logic [31:0] code_q, code_d;
  logic [31:0] addr_q, addr_d;
  logic        ds_q, ds_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  cnt_q, cnt_d;

  logic        irq_pending;
  logic [31:0] win_code;
  logic        unused_bits;

  assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

  // Priority encoder; a zero code means nothing to report.
  always_comb begin
    irq_pending = status_i[STATUS_IE_BIT] && !status_i[STATUS_EXL_BIT] &&
                  ((cause_i[CAUSE_IP_MSB:CAUSE_IP_LSB] &
                    status_i[STATUS_IM_MSB:STATUS_IM_LSB]) != 8'h00);
    win_code = 32'h0;
    if (irq_pending)                    win_code = EXC_CODE_INT;
    else if (exc_flags_i[FLAG_SYSCALL]) win_code = EXC_CODE_SYSCALL;
    else if (exc_flags_i[FLAG_RI])      win_code = EXC_CODE_RI;
    else if (exc_flags_i[FLAG_TRAP])    win_code = EXC_CODE_TRAP;
    else if (exc_flags_i[FLAG_OV])      win_code = EXC_CODE_OV;
    else if (exc_flags_i[FLAG_ERET])    win_code = EXC_CODE_ERET;
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    addr_d  = addr_q;
    ds_d    = ds_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (inst_valid_i && !stall_i && (win_code != 32'h0)) begin
          state_d = ST_COMMIT;
          code_d  = win_code;
          addr_d  = inst_addr_i;
          ds_d    = is_in_delayslot_i;
          pc_d    = (win_code == EXC_CODE_ERET) ? epc_i : EXC_VECTOR;
        end
      end
      ST_COMMIT: begin
        state_d = ST_DRAIN;
        cnt_d   = 3'(FLUSH_CYCLES - 1);
      end
      ST_DRAIN: begin
        if (cnt_q == 3'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      code_q  <= 32'h0;
      addr_q  <= 32'h0;
      ds_q    <= 1'b0;
      pc_q    <= 32'h0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      addr_q  <= addr_d;
      ds_q    <= ds_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // CP0 report and redirect are visible only during the single COMMIT cycle.
  always_comb begin
    excepttype_o    = 32'h0;
    cp0_inst_addr_o = 32'h0;
    cp0_delayslot_o = 1'b0;
    flush_o         = 1'b0;
    new_pc_o        = 32'h0;
    if (state_q == ST_COMMIT) begin
      excepttype_o    = code_q;
      cp0_inst_addr_o = addr_q;
      cp0_delayslot_o = ds_q;
      flush_o         = 1'b1;
      new_pc_o        = pc_q;
    end
    busy_o = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_except_ctrl.sv
// Directed bench for except_ctrl: commit/drain timing, priority, masking,
// stall handling and reset abort.
module tb_except_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid_i;
  logic        stall_i;
  logic [4:0]  exc_flags_i;
  logic [31:0] inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic [31:0] excepttype_o;
  logic [31:0] cp0_inst_addr_o;
  logic        cp0_delayslot_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        busy_o;

  int n_total = 0;
  int n_pass  = 0;

  except_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .inst_valid_i      (inst_valid_i),
    .stall_i           (stall_i),
    .exc_flags_i       (exc_flags_i),
    .inst_addr_i       (inst_addr_i),
    .is_in_delayslot_i (is_in_delayslot_i),
    .status_i          (status_i),
    .cause_i           (cause_i),
    .epc_i             (epc_i),
    .excepttype_o      (excepttype_o),
    .cp0_inst_addr_o   (cp0_inst_addr_o),
    .cp0_delayslot_o   (cp0_delayslot_o),
    .flush_o           (flush_o),
    .new_pc_o          (new_pc_o),
    .busy_o            (busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"},  {31'h0, busy_o},          32'h0);
    chk({tag, ".flush"}, {31'h0, flush_o},         32'h0);
    chk({tag, ".code"},  excepttype_o,             32'h0);
    chk({tag, ".addr"},  cp0_inst_addr_o,          32'h0);
    chk({tag, ".ds"},    {31'h0, cp0_delayslot_o}, 32'h0);
    chk({tag, ".pc"},    new_pc_o,                 32'h0);
  endtask

  task automatic chk_commit(input string tag, input logic [31:0] code, input logic [31:0] addr,
                            input logic ds, input logic [31:0] pc);
    chk({tag, ".busy"},  {31'h0, busy_o},          32'h1);
    chk({tag, ".flush"}, {31'h0, flush_o},         32'h1);
    chk({tag, ".code"},  excepttype_o,             code);
    chk({tag, ".addr"},  cp0_inst_addr_o,          addr);
    chk({tag, ".ds"},    {31'h0, cp0_delayslot_o}, {31'h0, ds});
    chk({tag, ".pc"},    new_pc_o,                 pc);
  endtask

  // DRAIN cycles: busy, but nothing reported and no flush.
  task automatic chk_drain(input string tag);
    chk({tag, ".busy"},  {31'h0, busy_o},  32'h1);
    chk({tag, ".flush"}, {31'h0, flush_o}, 32'h0);
    chk({tag, ".code"},  excepttype_o,     32'h0);
    chk({tag, ".pc"},    new_pc_o,         32'h0);
  endtask

  task automatic clr_inputs();
    inst_valid_i      = 1'b0;
    stall_i           = 1'b0;
    exc_flags_i       = 5'b0;
    inst_addr_i       = 32'h0;
    is_in_delayslot_i = 1'b0;
    status_i          = 32'h0;
    cause_i           = 32'h0;
    epc_i             = 32'h0;
  endtask

  initial begin
    rst = 1'b0;
    clr_inputs();
    tick();
    tick();
    chk_idle("reset");
    rst = 1'b1;
    tick();
    chk_idle("post_reset");

    // Syscall: commit one cycle, then 2 drain cycles, then idle.
    inst_valid_i = 1'b1; exc_flags_i = 5'b00001; inst_addr_i = 32'h100;
    tick();
    clr_inputs();
    chk_commit("sys", 32'h8, 32'h100, 1'b0, 32'h20);
    tick(); chk_drain("sys_drain1");
    tick(); chk_drain("sys_drain2");
    tick(); chk_idle("sys_idle");

    // Interrupt beats ovf; exactly one flush.
    inst_valid_i = 1'b1; exc_flags_i = 5'b01000; inst_addr_i = 32'h180;
    status_i = 32'h0000_0401; cause_i = 32'h0000_0400;
    tick();
    chk_commit("irq", 32'h1, 32'h180, 1'b0, 32'h20);
    tick(); chk_drain("irq_drain1");
    tick(); chk_drain("irq_drain2");
    clr_inputs();
    tick(); chk_idle("irq_idle");
    tick(); chk_idle("irq_idle2");

    // Eret held behind a 2-cycle stall.
    inst_valid_i = 1'b1; exc_flags_i = 5'b10000; inst_addr_i = 32'h1c0;
    epc_i = 32'h0000_4000; stall_i = 1'b1;
    tick(); chk_idle("eret_stall1");
    tick(); chk_idle("eret_stall2");
    stall_i = 1'b0;
    tick();
    epc_i = 32'h0000_9999;
    exc_flags_i = 5'b0; inst_valid_i = 1'b0;
    chk_commit("eret", 32'he, 32'h1c0, 1'b0, 32'h4000);
    tick(); chk_drain("eret_drain1");
    tick(); chk_drain("eret_drain2");
    clr_inputs();
    tick(); chk_idle("eret_idle");

    // Trap arriving in COMMIT/DRAIN is ignored, then taken once back in IDLE.
    inst_valid_i = 1'b1; exc_flags_i = 5'b00001; inst_addr_i = 32'h300;
    tick();
    chk_commit("sys2", 32'h8, 32'h300, 1'b0, 32'h20);
    exc_flags_i = 5'b00100; inst_addr_i = 32'h304; stall_i = 1'b1;
    tick(); chk_drain("trap_ign1");
    stall_i = 1'b0;
    tick(); chk_drain("trap_ign2");
    tick(); chk_idle("trap_wait");
    tick();
    clr_inputs();
    chk_commit("trap", 32'hd, 32'h304, 1'b0, 32'h20);
    tick(); tick(); tick();
    chk_idle("trap_idle");

    // Masked interrupt (EXL set): never commits.
    inst_valid_i = 1'b1; status_i = 32'h0000_0403; cause_i = 32'h0000_0400;
    tick(); chk_idle("masked1");
    tick(); chk_idle("masked2");

    // Unmasked interrupt waits for a valid slot; delay-slot flag reported.
    inst_valid_i = 1'b0; status_i = 32'h0000_0401; is_in_delayslot_i = 1'b1;
    inst_addr_i = 32'h400;
    tick(); chk_idle("irq_noslot");
    inst_valid_i = 1'b1;
    tick();
    clr_inputs();
    chk_commit("irq_ds", 32'h1, 32'h400, 1'b1, 32'h20);
    tick(); tick(); tick();
    chk_idle("irq_ds_idle");

    // All flags together: syscall wins; then trap beats ovf and eret.
    inst_valid_i = 1'b1; exc_flags_i = 5'b11111; inst_addr_i = 32'h500;
    tick();
    clr_inputs();
    chk_commit("all_flags", 32'h8, 32'h500, 1'b0, 32'h20);
    tick(); tick(); tick();
    inst_valid_i = 1'b1; exc_flags_i = 5'b11100; inst_addr_i = 32'h504; epc_i = 32'h7000;
    tick();
    clr_inputs();
    chk_commit("trap_ov_eret", 32'hd, 32'h504, 1'b0, 32'h20);
    tick(); tick(); tick();
    inst_valid_i = 1'b1; exc_flags_i = 5'b00010; inst_addr_i = 32'h508;
    tick();
    clr_inputs();
    chk_commit("ri", 32'ha, 32'h508, 1'b0, 32'h20);
    tick(); tick(); tick();
    inst_valid_i = 1'b1; exc_flags_i = 5'b01000; inst_addr_i = 32'h50c;
    tick();
    clr_inputs();
    chk_commit("ovf", 32'hc, 32'h50c, 1'b0, 32'h20);
    tick(); tick(); tick();
    chk_idle("ovf_idle");

    // Reset during DRAIN aborts the sequence.
    inst_valid_i = 1'b1; exc_flags_i = 5'b00001; inst_addr_i = 32'h600;
    tick();
    clr_inputs();
    chk_commit("rst_seq", 32'h8, 32'h600, 1'b0, 32'h20);
    tick(); chk_drain("rst_seq_drain");
    rst = 1'b0;
    tick(); chk_idle("rst_drain");
    rst = 1'b1;
    tick(); chk_idle("rst_drain_after");

    // Reset during COMMIT: no residual flush.
    inst_valid_i = 1'b1; exc_flags_i = 5'b00100; inst_addr_i = 32'h700;
    tick();
    clr_inputs();
    chk_commit("rst_c_seq", 32'hd, 32'h700, 1'b0, 32'h20);
    rst = 1'b0;
    tick(); chk_idle("rst_commit");
    rst = 1'b1;
    tick(); chk_idle("rst_commit_after");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/except_ctrl.md
EXCEPT_CTRL -- requirements
Module: except_ctrl

Interface
REQ-001 The block SHALL have parameter EXC_VECTOR, default 32'h0000_0020, the handler entry address for all non-eret exceptions.
REQ-002 The block SHALL have parameter FLUSH_CYCLES, default 2, the number of drain cycles after a commit (legal range 1..7).
REQ-003 The block SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- inst_valid_i  in  1  MEM-stage slot holds a real instruction.
- stall_i  in  1  MEM stage stalled this cycle.
- exc_flags_i  in  5  {eret, ovf, trap, inst_invalid, syscall} from the pipeline.
- inst_addr_i  in  32  MEM-stage instruction address.
- is_in_delayslot_i  in  1  MEM instruction is in a delay slot.
- status_i, cause_i, epc_i  in  32 each  forwarded CP0 values.
- excepttype_o  out  32  code to CP0.
- cp0_inst_addr_o  out  32  address to CP0.
- cp0_delayslot_o  out  1  delay-slot flag to CP0.
- flush_o  out  1  pipeline flush.
- new_pc_o  out  32  redirect target.
- busy_o  out  1  state is not IDLE.

Function
REQ-004 A pending interrupt SHALL be status_i[0]==1, status_i[1]==0, and (cause_i[15:8] & status_i[15:8])!=0.
REQ-005 Detection SHALL occur only in IDLE with inst_valid_i==1 and stall_i==0; otherwise nothing commits and inputs are re-evaluated next cycle.
REQ-006 Detection priority and codes SHALL be:
- interrupt 32'h1
- syscall 32'h8
- inst_invalid 32'ha
- trap 32'hd
- ovf 32'hc
- eret 32'he
REQ-007 On detection in cycle T, the block SHALL register the winning code. In cycle T+1 it SHALL drive excepttype_o, cp0_inst_addr_o and cp0_delayslot_o with the T values of code, inst_addr_i and is_in_delayslot_i, assert flush_o, and drive new_pc_o. All these outputs SHALL hold for exactly one cycle.
REQ-008 new_pc_o SHALL be epc_i as sampled at T for eret, and EXC_VECTOR for all other codes.
REQ-009 The FSM SHALL have three states:
- IDLE: goes to COMMIT on detection.
- COMMIT: one cycle, outputs per REQ-007; goes to DRAIN.
- DRAIN: lasts FLUSH_CYCLES cycles, counted by a 3-bit down-counter; goes to IDLE when the counter reaches 0.
REQ-010 In COMMIT and DRAIN, all inputs SHALL be ignored, including a new exception, an interrupt or stall_i. stall_i SHALL NOT extend COMMIT.
REQ-011 Outside COMMIT: excepttype_o SHALL be 0, flush_o 0, new_pc_o 0, cp0_inst_addr_o 0 and cp0_delayslot_o 0.
REQ-012 busy_o SHALL be 1 in COMMIT and DRAIN, and 0 in IDLE.
REQ-013 If several exc_flags_i bits are set at once, only the highest-priority one SHALL be reported. Lower ones are dropped, not queued.
REQ-014 An interrupt SHALL NOT be taken while inst_valid_i==0; it stays pending at the CP0 inputs until a valid, unstalled slot appears.

Reset
REQ-015 When rst==0 at a clock edge, the block SHALL enter IDLE, clear the drain counter and the registered code, and drive all outputs to 0 on the next cycle.
REQ-016 Reset asserted during COMMIT or DRAIN SHALL abort the sequence with no residual flush_o pulse.

Structure
REQ-017 The exception codes, CP0 status and cause bit positions, and the FSM state encoding SHALL live in the shared defines file used by the CPU.
REQ-018 The block SHALL be a single module with no sub-modules. Priority encoding SHALL be an internal combinational process.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Syscall: valid, syscall flag, inst_addr 0x100, not stalled at T -> at T+1 excepttype_o=8, cp0_inst_addr_o=0x100, flush_o=1, new_pc_o=0x20; busy_o high for 3 cycles; then IDLE.
- Interrupt plus ovf: status=0x0000_0401, cause[10]=1, ovf flag set at the same time -> excepttype_o=1 (interrupt wins); exactly one flush.
- Eret with stall: epc_i=0x0000_4000, eret flag, stall_i=1 for 2 cycles then 0 -> commit one cycle after stall releases; excepttype_o=0xe, new_pc_o=0x4000.
- Second exception during DRAIN: trap flag during DRAIN -> ignored, no second flush; the same trap presented again in IDLE -> excepttype_o=0xd.
- Masked interrupt: status[1]=1 (EXL set) with an interrupt pending -> no commit, excepttype_o stays 0.
- Reset mid-sequence: rst=0 during DRAIN -> next cycle busy_o=0 and all outputs 0.
